up_sample_hw_output_stream: RTL

Output-side stage of the up_sample pipeline, directly downstream of `nearest_neighbor_stencil_ub`. It runs the `op_hcompute_hw_output_stencil` iteration domain over the 128×128 upsampled image and drives that buffer's read-enable and 3-entry control-variable vector. Each combinational read result is captured into an output register and presented on a ready/valid stream. Consumer backpressure stalls the iteration counters, so no element is dropped or duplicated.

---
 rtl/up_sample_hw_output_stream.sv | 82 ++++++++
 1 files changed

// File: rtl/up_sample_hw_output_stream.sv
// up_sample_hw_output_stream: walks the 128x128 hw_output iteration domain, reads the stencil buffer and streams pixels out.
module up_sample_hw_output_stream #(
  parameter int WIDTH = 16,
  parameter int EXTENT_X = 128,
  parameter int EXTENT_Y = 128,
  parameter int START_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  output logic             op_hcompute_hw_output_stencil_read_ren,
  output logic [WIDTH-1:0] op_hcompute_hw_output_stencil_read_ctrl_vars [2:0],
  input  logic [WIDTH-1:0] op_hcompute_hw_output_stencil_read [0:0],
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done
);
  localparam int XW = EXTENT_X > 1 ? $clog2(EXTENT_X) : 1;
  localparam int YW = EXTENT_Y > 1 ? $clog2(EXTENT_Y) : 1;
  localparam int DW = $clog2(START_DELAY + 1) + 1;
  // WAIT lasts START_DELAY cycles, so the counter starts one below the delay
  localparam logic [DW-1:0] DLOAD = START_DELAY > 0 ? DW'(START_DELAY - 1) : '0;
  typedef enum logic [1:0] {IDLE, WAIT, RUN, DRAIN} state_t;
  state_t state, next;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [DW-1:0] cnt;
  logic ren, xfer, x_last, y_last;
  assign x_last = x == XW'(EXTENT_X - 1);
  assign y_last = y == YW'(EXTENT_Y - 1);
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = flush ? IDLE :
           state == IDLE ? (start ? (START_DELAY > 0 ? WAIT : RUN) : IDLE) :
           state == WAIT ? (cnt == '0 ? RUN : WAIT) :
           state == RUN ? (ren && x_last && y_last ? DRAIN : RUN) :
           xfer ? IDLE : DRAIN;
  end
  // the output register is only reloaded when it is empty or being drained this cycle
  always_comb begin
    ren = state == RUN && (!out_valid || out_ready) && !flush;
  end
  assign op_hcompute_hw_output_stencil_read_ren = ren;
  assign op_hcompute_hw_output_stencil_read_ctrl_vars[0] = '0;
  assign op_hcompute_hw_output_stencil_read_ctrl_vars[1] = WIDTH'(y);
  assign op_hcompute_hw_output_stencil_read_ctrl_vars[2] = WIDTH'(x);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= '0;
      y <= '0;
      cnt <= '0;
    end else if (flush) begin
      x <= '0;
      y <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && start) cnt <= DLOAD;
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (ren) begin
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) y <= y_last ? '0 : y + 1'b1;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_data <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= !flush && state == DRAIN && xfer;
      if (flush) out_valid <= 1'b0;
      else if (ren) begin
        out_data <= op_hcompute_hw_output_stencil_read[0];
        out_valid <= 1'b1;
      end else if (xfer) out_valid <= 1'b0;
    end
endmodule
